// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter
// encoding, the BTB entry layout and the saturating counter update.
package bp_pkg;

  // Two-bit saturating direction counter; bit 1 is the predicted direction.
  localparam logic [1:0] CTR_SNT   = 2'b00;  // strong not-taken
  localparam logic [1:0] CTR_WNT   = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_WT    = 2'b10;  // weak taken
  localparam logic [1:0] CTR_ST    = 2'b11;  // strong taken
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Entry layout for the default geometry (16 entries, 32-bit PC).
  localparam int BP_PC_WIDTH = 32;
  localparam int BP_ENTRIES  = 16;
  localparam int BP_TAG_W    = BP_PC_WIDTH - $clog2(BP_ENTRIES) - 2;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_W-1:0]    tag;
    logic [BP_PC_WIDTH-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  // Move the counter one step toward the resolved direction, saturating.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr,
                                            input logic       taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage: one combinational lookup port for fetch, one
// combinational read port for the resolving branch, and one write port
// addressed by that same resolving branch. Reads return pre-write contents.
module bp_btb_table
  import bp_pkg::*;
#(
  parameter  int ENTRIES  = 16,
  parameter  int PC_WIDTH = 32,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int TAG_W    = PC_WIDTH - IDX_W - 2
) (
  input  logic                clk,
  input  logic                rst,
  // fetch lookup port
  input  logic [IDX_W-1:0]    i_lk_idx,
  input  logic [TAG_W-1:0]    i_lk_tag,
  output logic                o_lk_hit,
  output logic                o_lk_taken,
  output logic [PC_WIDTH-1:0] o_lk_target,
  // resolve-side read port (also addresses the write)
  input  logic [IDX_W-1:0]    i_up_idx,
  input  logic [TAG_W-1:0]    i_up_tag,
  output logic                o_up_hit,
  output logic [1:0]          o_up_ctr,
  output logic [PC_WIDTH-1:0] o_up_target,
  // write port; a write always marks the entry valid and installs i_up_tag
  input  logic                i_wr_en,
  input  logic [1:0]          i_wr_ctr,
  input  logic [PC_WIDTH-1:0] i_wr_target
);

  logic [ENTRIES-1:0]  r_valid;
  logic [1:0]          r_ctr    [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];

  // Valid bits and counters are reset; writes are suppressed in a reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (i_wr_en) begin
      r_valid[i_up_idx] <= 1'b1;
      r_ctr[i_up_idx]   <= i_wr_ctr;
    end
  end

  // Tag and target need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && i_wr_en) begin
      r_tag[i_up_idx]    <= i_up_tag;
      r_target[i_up_idx] <= i_wr_target;
    end
  end

  assign o_lk_hit    = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
  assign o_lk_taken  = r_ctr[i_lk_idx][1];
  assign o_lk_target = r_target[i_lk_idx];

  assign o_up_hit    = r_valid[i_up_idx] && (r_tag[i_up_idx] == i_up_tag);
  assign o_up_ctr    = r_ctr[i_up_idx];
  assign o_up_target = r_target[i_up_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor. Predicts from the BTB in F, carries
// the prediction through D and E for the controller, and trains the BTB when
// a conditional branch resolves in E.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] F_pc,
  input  logic                stall,
  input  logic                flush,
  output logic                F_pred_taken,
  output logic [PC_WIDTH-1:0] F_pred_target,
  output logic                E_pred_taken,
  output logic                E_pred_valid,
  input  logic                E_is_branch,
  input  logic                E_branch_taken,
  input  logic [PC_WIDTH-1:0] E_pc,
  input  logic [PC_WIDTH-1:0] E_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  // Instruction addresses are word aligned, so the two low bits carry nothing.
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{F_pc[1:0], E_pc[1:0]};

  logic [IDX_W-1:0]    w_f_idx, w_e_idx;
  logic [TAG_W-1:0]    w_f_tag, w_e_tag;
  logic                w_f_hit, w_f_taken;
  logic [PC_WIDTH-1:0] w_f_target;
  logic                w_e_hit;
  logic [1:0]          w_e_ctr;
  logic [PC_WIDTH-1:0] w_e_target_old;
  logic                w_wr_en;
  logic [1:0]          w_wr_ctr;
  logic [PC_WIDTH-1:0] w_wr_target;

  logic r_d_pred_valid, r_d_pred_taken;
  logic r_e_pred_valid, r_e_pred_taken;

  assign w_f_idx = F_pc[IDX_W+1:2];
  assign w_f_tag = F_pc[PC_WIDTH-1:IDX_W+2];
  assign w_e_idx = E_pc[IDX_W+1:2];
  assign w_e_tag = E_pc[PC_WIDTH-1:IDX_W+2];

  bp_btb_table #(
    .ENTRIES  (ENTRIES),
    .PC_WIDTH (PC_WIDTH)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_lk_idx    (w_f_idx),
    .i_lk_tag    (w_f_tag),
    .o_lk_hit    (w_f_hit),
    .o_lk_taken  (w_f_taken),
    .o_lk_target (w_f_target),
    .i_up_idx    (w_e_idx),
    .i_up_tag    (w_e_tag),
    .o_up_hit    (w_e_hit),
    .o_up_ctr    (w_e_ctr),
    .o_up_target (w_e_target_old),
    .i_wr_en     (w_wr_en),
    .i_wr_ctr    (w_wr_ctr),
    .i_wr_target (w_wr_target)
  );

  assign F_pred_taken  = w_f_hit && w_f_taken;
  assign F_pred_target = w_f_hit ? w_f_target : '0;

  // Train on a hit, allocate weak-taken on a taken miss, ignore not-taken misses.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_ctr    = w_e_ctr;
    w_wr_target = w_e_target_old;
    if (E_is_branch) begin
      if (w_e_hit) begin
        w_wr_en  = 1'b1;
        w_wr_ctr = sat_update(w_e_ctr, E_branch_taken);
        if (E_branch_taken) w_wr_target = E_target;
      end else if (E_branch_taken) begin
        w_wr_en     = 1'b1;
        w_wr_ctr    = CTR_WT;
        w_wr_target = E_target;
      end
    end
  end

  // F->D prediction register: flush clears, stall holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_d_pred_valid <= 1'b0;
      r_d_pred_taken <= 1'b0;
    end else if (!stall) begin
      r_d_pred_valid <= w_f_hit;
      r_d_pred_taken <= F_pred_taken;
    end
  end

  // D->E prediction register: stall or flush inserts the same bubble as the controller.
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      r_e_pred_valid <= 1'b0;
      r_e_pred_taken <= 1'b0;
    end else begin
      r_e_pred_valid <= r_d_pred_valid;
      r_e_pred_taken <= r_d_pred_taken;
    end
  end

  assign E_pred_valid = r_e_pred_valid;
  assign E_pred_taken = r_e_pred_taken;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each driven cycle pushes the
// hand-computed outputs for that cycle; a monitor pops and compares mid-cycle.
module tb_branch_predictor;

  localparam int PW = 32;
  localparam int W  = PW + 3;  // {F_pred_taken, F_pred_target, E_pred_valid, E_pred_taken}

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst            = 1'b1;
  logic [PW-1:0] F_pc           = '0;
  logic          stall          = 1'b0;
  logic          flush          = 1'b0;
  logic          E_is_branch    = 1'b0;
  logic          E_branch_taken = 1'b0;
  logic [PW-1:0] E_pc           = '0;
  logic [PW-1:0] E_target       = '0;
  logic          F_pred_taken;
  logic [PW-1:0] F_pred_target;
  logic          E_pred_taken;
  logic          E_pred_valid;

  branch_predictor #(.ENTRIES(16), .PC_WIDTH(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .F_pc           (F_pc),
    .stall          (stall),
    .flush          (flush),
    .F_pred_taken   (F_pred_taken),
    .F_pred_target  (F_pred_target),
    .E_pred_taken   (E_pred_taken),
    .E_pred_valid   (E_pred_valid),
    .E_is_branch    (E_is_branch),
    .E_branch_taken (E_branch_taken),
    .E_pc           (E_pc),
    .E_target       (E_target)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] m_exp, m_act;
  string        m_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_nm  = name_q.pop_front();
      m_act = {F_pred_taken, F_pred_target, E_pred_valid, E_pred_taken};
      n_checks++;
      if (m_act !== m_exp) begin
        n_errors++;
        $display("FAIL %s: got ft=%0d tgt=%h ev=%0d et=%0d, want ft=%0d tgt=%h ev=%0d et=%0d",
                 m_nm, m_act[W-1], m_act[W-2:2], m_act[1], m_act[0],
                 m_exp[W-1], m_exp[W-2:2], m_exp[1], m_exp[0]);
      end
    end
  end

  // Driver tasks
  task automatic step(input logic r, input logic [PW-1:0] pc, input logic st,
                      input logic fl, input logic eb, input logic etk,
                      input logic [PW-1:0] epc, input logic [PW-1:0] etgt,
                      input logic eft, input logic [PW-1:0] eftgt,
                      input logic eev, input logic eet, input string nm);
    @(posedge clk);
    #1;
    rst            = r;
    F_pc           = pc;
    stall          = st;
    flush          = fl;
    E_is_branch    = eb;
    E_branch_taken = etk;
    E_pc           = epc;
    E_target       = etgt;
    exp_q.push_back({eft, eftgt, eev, eet});
    name_q.push_back(nm);
  endtask

  task automatic f(input logic [PW-1:0] pc, input logic st, input logic fl,
                   input logic eft, input logic [PW-1:0] eftgt,
                   input logic eev, input logic eet, input string nm);
    step(1'b0, pc, st, fl, 1'b0, 1'b0, '0, '0, eft, eftgt, eev, eet, nm);
  endtask

  task automatic b(input logic [PW-1:0] pc, input logic st, input logic tk,
                   input logic [PW-1:0] epc, input logic [PW-1:0] etgt,
                   input logic eft, input logic [PW-1:0] eftgt,
                   input logic eev, input logic eet, input string nm);
    step(1'b0, pc, st, 1'b0, 1'b1, tk, epc, etgt, eft, eftgt, eev, eet, nm);
  endtask

  initial begin
    // reset
    step(1'b1, 32'h100, 0, 0, 0, 0, '0, '0, 0, 32'h0, 0, 0, "reset_0");
    step(1'b1, 32'h100, 0, 0, 0, 0, '0, '0, 0, 32'h0, 0, 0, "reset_1");
    // cold miss, then first allocation with a same-cycle lookup
    f(32'h100, 0, 0, 0, 32'h0,  0, 0, "cold_miss");
    f(32'h200, 0, 0, 0, 32'h0,  0, 0, "cold_miss_alias");
    b(32'h100, 0, 1, 32'h100, 32'h80, 0, 32'h0, 0, 0, "same_cycle_alloc_miss");
    f(32'h100, 0, 0, 1, 32'h80, 0, 0, "alloc_hit");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "other_tag_miss");
    // training: 10 -> 11 -> 11 -> 11 -> 10 -> 01
    b(32'h300, 0, 1, 32'h100, 32'h80, 0, 32'h0, 1, 1, "e_pred_after_2");
    b(32'h300, 0, 1, 32'h100, 32'h80, 0, 32'h0, 0, 0, "train_t2");
    b(32'h300, 0, 1, 32'h100, 32'h80, 0, 32'h0, 0, 0, "train_t3");
    b(32'h300, 0, 0, 32'h100, 32'h0,  0, 32'h0, 0, 0, "train_nt1");
    b(32'h100, 0, 0, 32'h100, 32'h0,  1, 32'h80, 0, 0, "ctr10_taken");
    f(32'h100, 0, 0, 0, 32'h80, 0, 0, "ctr01_hit_nt");
    f(32'h300, 0, 0, 0, 32'h0,  1, 1, "e_hit_taken");
    // low saturation: 01 -> 00 -> 00 -> 01 (target rewritten) -> 10
    b(32'h300, 0, 0, 32'h100, 32'h0,  0, 32'h0, 1, 0, "e_hit_not_taken");
    b(32'h300, 0, 0, 32'h100, 32'h0,  0, 32'h0, 0, 0, "train_nt_sat");
    b(32'h300, 0, 1, 32'h100, 32'h90, 0, 32'h0, 0, 0, "train_t_from00");
    b(32'h100, 0, 1, 32'h100, 32'h90, 0, 32'h90, 0, 0, "sat_low_ctr01");
    f(32'h100, 0, 0, 1, 32'h90, 0, 0, "ctr10_new_target");
    f(32'h300, 0, 0, 0, 32'h0,  1, 0, "e_hit_nt_pred");
    // aliasing: 0x140 shares index 0 with 0x100
    b(32'h300, 0, 1, 32'h140, 32'h44, 0, 32'h0, 1, 1, "alias_alloc");
    f(32'h100, 0, 0, 0, 32'h0,  0, 0, "alias_evicted");
    f(32'h140, 0, 0, 1, 32'h44, 0, 0, "alias_hit");
    f(32'h140, 0, 0, 1, 32'h44, 0, 0, "alias_hit2");
    // stall for two cycles: D holds, E bubbles
    f(32'h300, 1, 0, 0, 32'h0,  1, 1, "stall_first");
    f(32'h300, 1, 0, 0, 32'h0,  0, 0, "stall_bubble");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "stall_bubble2");
    f(32'h300, 0, 0, 0, 32'h0,  1, 1, "stall_held_d");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "after_stall");
    // flush clears both registers
    f(32'h140, 0, 0, 1, 32'h44, 0, 0, "pre_flush_hit");
    f(32'h140, 0, 1, 1, 32'h44, 0, 0, "flush_cycle");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "flush_e_cleared");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "flush_d_cleared");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "after_flush");
    // flush wins over stall
    f(32'h140, 0, 0, 1, 32'h44, 0, 0, "pre_fs_hit");
    f(32'h300, 1, 1, 0, 32'h0,  0, 0, "flush_stall_cycle");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "fs_bubble");
    f(32'h300, 0, 0, 0, 32'h0,  0, 0, "flush_over_stall");
    // update proceeds under stall; not-taken miss leaves the table alone
    b(32'h300, 1, 1, 32'h140, 32'h48, 0, 32'h0, 0, 0, "stall_update_cycle");
    b(32'h140, 0, 0, 32'h180, 32'h0,  1, 32'h48, 0, 0, "update_during_stall");
    f(32'h140, 0, 0, 1, 32'h48, 0, 0, "nt_miss_no_alloc");
    // second index, and PC low bits ignored
    b(32'h180, 0, 1, 32'h104, 32'h200, 0, 32'h0, 1, 1, "other_idx_alloc");
    f(32'h104, 0, 0, 1, 32'h200, 1, 1, "idx1_hit");
    f(32'h140, 0, 0, 1, 32'h48,  0, 0, "idx0_intact");
    f(32'h107, 0, 0, 1, 32'h200, 1, 1, "low_bits_ignored");
    // mid-run reset with a would-be update in the reset cycle
    step(1'b1, 32'h104, 0, 0, 1, 1, 32'h184, 32'h10, 1, 32'h200, 1, 1, "pre_reset");
    f(32'h104, 0, 0, 0, 32'h0, 0, 0, "reset_clears_btb");
    f(32'h184, 0, 0, 0, 32'h0, 0, 0, "no_update_in_reset");
    f(32'h140, 0, 0, 0, 32'h0, 0, 0, "reset_idx0_miss");
    f(32'h107, 0, 0, 0, 32'h0, 0, 0, "reset_e_clear");

    // Final report
    repeat (3) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
